// File: rtl/pattern_generator_multilane_seq.sv
// pattern_generator_multilane_seq
//   NumLanes pattern_generator cores sharing one seed/mode configuration,
//   driven by a start-level sequencer (IDLE/LOAD/SEED/RUN/FAIL) that also
//   watches the self-seed lock against a timeout.
//   Optional feature macro: PGEN_ERR_INJECT_EN (single-bit error injection
//   into the registered lane outputs, with a saturating injection counter).
//
// Core stepping: the core controls are decoded from the *next* state so the
// core advances on the same edge that data_out captures its word. The first
// RUN word is therefore the first word generated from the loaded seed, and no
// word is repeated or skipped at the LOAD->RUN or SEED->RUN boundary.

// Single-lane generator: PRBS (Fibonacci LFSR, OutBits bits per cycle, bit 0
// oldest) or a rotating fixed pattern. Self-seed shifts the incoming stream
// into the LFSR and flags lock when every incoming bit matched the LFSR's
// prediction and the state is nonzero (an all-zero stream never locks).
module pattern_generator #(
  parameter int OutBits    = 16,
  parameter int PattLength = 32,
  parameter int PRBSLength = 31,
  parameter int SeedLength = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  run,
  input  logic                  seed,
  input  logic                  pattern,
  input  logic                  out_inv,
  input  logic [SeedLength-1:0] load_in,
  input  logic [OutBits-1:0]    seed_in,
  output logic [OutBits-1:0]    out,
  output logic                  seed_good
);

  // Second feedback tap for the supported PRBS lengths (first tap is the MSB).
  localparam int Tap = (PRBSLength == 7)  ? 6  :
                       (PRBSLength == 9)  ? 5  :
                       (PRBSLength == 15) ? 14 :
                       (PRBSLength == 23) ? 18 : 28;

  logic [PRBSLength-1:0] prbs_q, prbs_gen, prbs_abs;
  logic [PattLength-1:0] patt_q, patt_rot;
  logic [OutBits-1:0]    prbs_bits;
  logic                  abs_match;

  // Generate the next OutBits PRBS bits and the advanced LFSR state.
  always_comb begin
    prbs_gen  = prbs_q;
    prbs_bits = '0;
    for (int j = 0; j < OutBits; j++) begin
      prbs_bits[j] = prbs_gen[PRBSLength-1] ^ prbs_gen[Tap-1];
      prbs_gen     = {prbs_gen[PRBSLength-2:0], prbs_bits[j]};
    end
  end

  // Absorb the incoming word and check it against the LFSR prediction.
  always_comb begin
    prbs_abs  = prbs_q;
    abs_match = 1'b1;
    for (int j = 0; j < OutBits; j++) begin
      if ((prbs_abs[PRBSLength-1] ^ prbs_abs[Tap-1]) != seed_in[j]) abs_match = 1'b0;
      prbs_abs = {prbs_abs[PRBSLength-2:0], seed_in[j]};
    end
  end

  // Pattern consumes its low OutBits each cycle, rotating them to the top.
  assign patt_rot = {patt_q[OutBits-1:0], patt_q[PattLength-1:OutBits]};
  assign out      = (pattern ? patt_q[OutBits-1:0] : prbs_bits) ^ {OutBits{out_inv}};

  // Generator state: load has priority, then self-seed, then free run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prbs_q    <= '0;
      patt_q    <= '0;
      seed_good <= 1'b0;
    end else if (load) begin
      prbs_q    <= load_in[PRBSLength-1:0];
      patt_q    <= load_in[PattLength-1:0];
      seed_good <= 1'b0;
    end else if (seed) begin
      prbs_q    <= prbs_abs;
      seed_good <= abs_match && (prbs_abs != '0);
    end else if (run) begin
      if (pattern) patt_q <= patt_rot;
      else         prbs_q <= prbs_gen;
    end
  end

endmodule

module pattern_generator_multilane_seq #(
  parameter int NumLanes    = 4,
  parameter int OutBits     = 16,
  parameter int PattLength  = 32,
  parameter int PRBSLength  = 31,
  parameter int SeedCycles  = 64,
  parameter int SeedTimeout = 1024,
  localparam int SeedLength = (PattLength > PRBSLength) ? PattLength : PRBSLength,
  localparam int LaneW      = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic                          cfg_pattern,
  input  logic                          cfg_self_seed,
  input  logic [SeedLength-1:0]         cfg_seed,
  input  logic [NumLanes-1:0]           cfg_inv,
  input  logic [NumLanes*OutBits-1:0]   pgen_seed_in,
  output logic [NumLanes*OutBits-1:0]   data_out,
  output logic                          data_valid,
  output logic [NumLanes-1:0]           seed_good,
  output logic [2:0]                    state_out,
  output logic                          timeout_err
`ifdef PGEN_ERR_INJECT_EN
  ,
  input  logic                          err_inj,
  input  logic [LaneW-1:0]              err_inj_lane,
  output logic [15:0]                   err_inj_count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEED = 3'd2,
    RUN  = 3'd3,
    FAIL = 3'd4
  } state_t;

  localparam logic [15:0] SeedLast = 16'(SeedCycles - 1);
  localparam logic [15:0] SeedEnd  = 16'(SeedTimeout - 1);

  state_t                            state, nxt;
  logic                              start_m, start_s;
  logic                              mode_pattern, mode_self_seed;
  logic                              load_cnt;
  logic [15:0]                       seed_cnt;
  logic [NumLanes-1:0]               inv_q;
  logic                              core_load, core_run, core_seed;
  logic [NumLanes-1:0][OutBits-1:0]  core_out;
  logic [NumLanes-1:0][OutBits-1:0]  inj_mask;

  assign state_out = state;

  // Next-state decode; a synced stop overrides everything outside IDLE.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start_s) nxt = LOAD;
      LOAD: if (load_cnt) nxt = (mode_self_seed && !mode_pattern) ? SEED : RUN;
      SEED: begin
        if ((seed_cnt >= SeedLast) && (&seed_good)) nxt = RUN;
        else if (seed_cnt == SeedEnd)               nxt = FAIL;
      end
      RUN:  nxt = RUN;
      FAIL: nxt = FAIL;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && !start_s) nxt = IDLE;
  end

  // Core controls follow the state being entered (see header).
  always_comb begin
    core_load = (nxt == IDLE) || (nxt == LOAD) || (nxt == FAIL);
    core_seed = (nxt == SEED);
    core_run  = (nxt == SEED) || (nxt == RUN);
  end

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    pattern_generator #(
      .OutBits   (OutBits),
      .PattLength(PattLength),
      .PRBSLength(PRBSLength),
      .SeedLength(SeedLength)
    ) u_pgen (
      .clk      (clk),
      .reset    (1'b0),
      .load     (core_load),
      .run      (core_run),
      .seed     (core_seed),
      .pattern  (mode_pattern),
      .out_inv  (inv_q[i]),
      .load_in  (cfg_seed),
      .seed_in  (pgen_seed_in[i*OutBits +: OutBits]),
      .out      (core_out[i]),
      .seed_good(seed_good[i])
    );
  end

`ifdef PGEN_ERR_INJECT_EN
  logic [2:0] inj_sync;
  logic       inj_hit;

  // Rising edge of the synchronized pulse, honoured only while running.
  assign inj_hit = inj_sync[1] && !inj_sync[2] && (state == RUN);

  // Flip bit 0 of the selected lane for the single cycle of a hit.
  always_comb begin
    inj_mask = '0;
    if (inj_hit) inj_mask[err_inj_lane][0] = 1'b1;
  end

  // Injection synchronizer/edge history and saturating hit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_sync      <= '0;
      err_inj_count <= '0;
    end else begin
      inj_sync <= {inj_sync[1:0], err_inj};
      if (inj_hit && err_inj_count != 16'hFFFF) err_inj_count <= err_inj_count + 16'd1;
    end
  end
`else
  assign inj_mask = '0;
`endif

  // Sequencer state, captured config, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      start_m        <= 1'b0;
      start_s        <= 1'b0;
      mode_pattern   <= 1'b0;
      mode_self_seed <= 1'b0;
      load_cnt       <= 1'b0;
      seed_cnt       <= '0;
      inv_q          <= '0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      start_m <= cfg_start;
      start_s <= start_m;
      inv_q   <= cfg_inv;
      state   <= nxt;
      if (state == IDLE && nxt == LOAD) begin
        mode_pattern   <= cfg_pattern;
        mode_self_seed <= cfg_self_seed;
      end
      load_cnt <= (state == LOAD) && (nxt == LOAD);
      if (state != SEED)      seed_cnt <= '0;
      else if (nxt == SEED)   seed_cnt <= seed_cnt + 16'd1;
      data_out    <= (nxt == RUN) ? (core_out ^ inj_mask) : '0;
      data_valid  <= (nxt == RUN);
      timeout_err <= (nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pattern_generator_multilane_seq.sv
// Bench for pattern_generator_multilane_seq (default parameters).
module tb_pattern_generator_multilane_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_pattern, cfg_self_seed;
  logic [31:0] cfg_seed;
  logic [3:0]  cfg_inv;
  logic [63:0] pgen_seed_in;
  logic [63:0] data_out;
  logic        data_valid;
  logic [3:0]  seed_good;
  logic [2:0]  state_out;
  logic        timeout_err;
`ifdef PGEN_ERR_INJECT_EN
  logic        err_inj;
  logic [1:0]  err_inj_lane;
  logic [15:0] err_inj_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference PRBS31 word streams, one per lane, derived from x^31+x^28+1.
  logic [15:0] strm [4][256];
  bit          feed_en = 1'b0;
  int          feed_idx = 0;

  always #5 clk = ~clk;

  pattern_generator_multilane_seq dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_pattern(cfg_pattern),
    .cfg_self_seed(cfg_self_seed), .cfg_seed(cfg_seed), .cfg_inv(cfg_inv),
    .pgen_seed_in(pgen_seed_in), .data_out(data_out), .data_valid(data_valid),
    .seed_good(seed_good), .state_out(state_out), .timeout_err(timeout_err)
`ifdef PGEN_ERR_INJECT_EN
    , .err_inj(err_inj), .err_inj_lane(err_inj_lane), .err_inj_count(err_inj_count)
`endif
  );

  // Bit n of the sequence = bit(n-31) xor bit(n-28); seed bit k is bit(-1-k).
  function automatic void fill_stream(input int lane, input logic [30:0] s0);
    bit h[$];
    for (int k = 30; k >= 0; k--) h.push_back(s0[k]);
    for (int c = 0; c < 256; c++) begin
      logic [15:0] w;
      for (int j = 0; j < 16; j++) begin
        bit b;
        b = h[h.size()-31] ^ h[h.size()-28];
        h.push_back(b);
        w[j] = b;
      end
      strm[lane][c] = w;
    end
  endfunction

  task automatic drive_feed();
    for (int i = 0; i < 4; i++) pgen_seed_in[i*16 +: 16] = strm[i][feed_idx];
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (feed_en) begin
      feed_idx++;
      drive_feed();
    end
  endtask

  task automatic go_idle();
    cfg_start = 1'b0;
    repeat (4) step();
  endtask

  // Raise start and count edges until data_valid (bounded).
  task automatic start_wait(output int lat, output int seed_cyc);
    lat = 0; seed_cyc = 0;
    cfg_start = 1'b1;
    while (data_valid !== 1'b1 && lat < 3000) begin
      step();
      lat++;
      if (state_out == 3'd2) seed_cyc++;
    end
  endtask

  task automatic test_reset();
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_prbs(input logic [30:0] s, input logic [3:0] inv);
    int lat, sc;
    logic [63:0] exp_w;
    fill_stream(0, s);
    cfg_pattern = 1'b0; cfg_self_seed = 1'b0; cfg_seed = {1'b0, s}; cfg_inv = inv;
    repeat (2) step();
    start_wait(lat, sc);
    checks++; if (lat != 5) begin errors++; $display("FAIL prbs_latency: got %0d want 5", lat); end
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) exp_w[i*16 +: 16] = strm[0][c] ^ {16{inv[i]}};
      checks++;
      if (data_out !== exp_w || data_valid !== 1'b1) begin
        errors++; $display("FAIL prbs_word%0d: got %h v=%b want %h", c, data_out, data_valid, exp_w);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_pattern(input logic [31:0] p, input logic [3:0] inv);
    int lat, sc;
    logic [63:0] exp_w;
    cfg_pattern = 1'b1; cfg_self_seed = 1'b1; cfg_seed = p; cfg_inv = inv;
    repeat (2) step();
    start_wait(lat, sc);
    checks++; if (lat != 5) begin errors++; $display("FAIL pattern_latency: got %0d want 5", lat); end
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++)
        exp_w[i*16 +: 16] = ((c % 2 == 0) ? p[15:0] : p[31:16]) ^ {16{inv[i]}};
      checks++;
      if (data_out !== exp_w) begin
        errors++; $display("FAIL pattern_word%0d: got %h want %h", c, data_out, exp_w);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_self_seed();
    int lat, sc;
    logic [63:0] exp_w;
    for (int i = 0; i < 4; i++) fill_stream(i, 31'($urandom_range(1, 32'h7FFF_FFFF)));
    cfg_pattern = 1'b0; cfg_self_seed = 1'b1; cfg_inv = 4'h0; cfg_seed = $urandom;
    feed_idx = 0; feed_en = 1'b1; drive_feed();
    step();
    start_wait(lat, sc);
    checks++; if (sc < 64) begin errors++; $display("FAIL seed_duration: got %0d want >=64", sc); end
    checks++; if (lat != 5 + sc) begin errors++; $display("FAIL seed_latency: got %0d want %0d", lat, 5 + sc); end
    checks++; if (seed_good !== 4'hF) begin errors++; $display("FAIL seed_good: got %h want f", seed_good); end
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) exp_w[i*16 +: 16] = strm[i][feed_idx-1];
      checks++;
      if (data_out !== exp_w || state_out !== 3'd3) begin
        errors++; $display("FAIL seed_track%0d: got %h st=%0d want %h", c, data_out, state_out, exp_w);
      end
      step();
    end
    feed_en = 1'b0;
    go_idle();
  endtask

  task automatic test_timeout();
    int n, guard;
    cfg_pattern = 1'b0; cfg_self_seed = 1'b1; pgen_seed_in = '0; cfg_seed = 32'h1234_5678;
    cfg_start = 1'b1;
    guard = 0;
    while (state_out !== 3'd2 && guard < 20) begin step(); guard++; end
    n = 0;
    while (state_out === 3'd2 && n < 3000) begin step(); n++; end
    checks++; if (n != 1024) begin errors++; $display("FAIL timeout_cycles: got %0d want 1024", n); end
    checks++;
    if (state_out !== 3'd4 || timeout_err !== 1'b1 || data_out !== 64'h0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_state: st=%0d err=%b d=%h v=%b want 4/1/0/0", state_out, timeout_err, data_out, data_valid);
    end
    repeat (5) step();
    checks++; if (state_out !== 3'd4) begin errors++; $display("FAIL fail_hold: got %0d want 4", state_out); end
    cfg_start = 1'b0;
    repeat (3) step();
    checks++;
    if (state_out !== 3'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL fail_exit: st=%0d err=%b want 0/0", state_out, timeout_err);
    end
    step();
  endtask

  task automatic test_stop_and_reset();
    int lat, sc;
    cfg_pattern = 1'b0; cfg_self_seed = 1'b0; cfg_inv = 4'h0;
    cfg_seed = {1'b0, 31'($urandom_range(1, 32'h7FFF_FFFF))};
    step();
    start_wait(lat, sc);
    repeat (3) step();
    cfg_start = 1'b0;
    repeat (3) step();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 64'h0 || state_out !== 3'd0) begin
      errors++; $display("FAIL stop: v=%b d=%h st=%0d want 0/0/0", data_valid, data_out, state_out);
    end
    step();
    start_wait(lat, sc);
    checks++; if (lat != 5) begin errors++; $display("FAIL restart_latency: got %0d want 5", lat); end
    repeat (2) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_valid !== 1'b0 || data_out !== 64'h0 || state_out !== 3'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: v=%b d=%h st=%0d want 0/0/0", data_valid, data_out, state_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start_wait(lat, sc);
    checks++; if (lat != 5) begin errors++; $display("FAIL post_reset_latency: got %0d want 5", lat); end
    go_idle();
  endtask

`ifdef PGEN_ERR_INJECT_EN
  task automatic test_err_inject();
    int lat, sc, flips, bad;
    cfg_pattern = 1'b1; cfg_seed = 32'hF0F0_F0F0; cfg_inv = 4'h0; err_inj_lane = 2'd2;
    step();
    start_wait(lat, sc);
    err_inj = 1'b1; step(); err_inj = 1'b0;
    flips = 0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (data_out[47:32] === 16'hF0F1) flips++;
      else if (data_out[47:32] !== 16'hF0F0) bad++;
      if (data_out[31:0] !== 32'hF0F0_F0F0 || data_out[63:48] !== 16'hF0F0) bad++;
    end
    checks++; if (flips != 1 || bad != 0) begin errors++; $display("FAIL inj_flip: flips=%0d bad=%0d want 1/0", flips, bad); end
    checks++; if (err_inj_count !== 16'd1) begin errors++; $display("FAIL inj_count: got %0d want 1", err_inj_count); end
    go_idle();
    err_inj = 1'b1; step(); err_inj = 1'b0;
    repeat (5) step();
    checks++; if (err_inj_count !== 16'd1) begin errors++; $display("FAIL inj_idle: got %0d want 1", err_inj_count); end
  endtask
`endif

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_pattern = 1'b0; cfg_self_seed = 1'b0;
    cfg_seed = '0; cfg_inv = '0; pgen_seed_in = '0;
`ifdef PGEN_ERR_INJECT_EN
    err_inj = 1'b0; err_inj_lane = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    repeat (2) step();
    test_prbs(31'h1, 4'h0);
    test_prbs(31'($urandom_range(1, 32'h7FFF_FFFF)), 4'($urandom));
    test_pattern(32'hF0F0_F0F0, 4'b0010);
    test_pattern($urandom, 4'($urandom));
    test_self_seed();
    test_timeout();
    test_stop_and_reset();
`ifdef PGEN_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_generator_multilane_seq.md
Name: pattern_generator_multilane_seq

Overview:
Multi-lane successor to the single-way pattern generator config wrapper. It instantiates NumLanes pattern_generator cores that share one seed/mode configuration, each with its own output invert and self-seed input. An on-chip sequencer FSM replaces manual load/seed/run bit toggling, which removes scan-chain ordering hazards in the TX stimulus path. It also checks self-seed lock against a timeout and reports status.

Parameters:
NumLanes, 4, number of parallel generator lanes
OutBits, 16, output bits per lane per cycle
PattLength, 32, fixed-pattern length
PRBSLength, 31, PRBS polynomial length
SeedCycles, 64, minimum self-seed cycles before lock may be declared
SeedTimeout, 1024, self-seed cycles before FAIL (must exceed SeedCycles)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cfg_start  in  1  level; 1=start/run, 0=stop; asynchronous to clk
cfg_pattern  in  1  1=pattern mode, 0=PRBS
cfg_self_seed  in  1  1=self-seed PRBS from pgen_seed_in
cfg_seed  in  SeedLength  load seed/pattern; SeedLength=max(PattLength,PRBSLength)
cfg_inv  in  NumLanes  per-lane output invert
pgen_seed_in  in  NumLanes*OutBits  per-lane self-seed data (lane i at [i*OutBits+:OutBits])
data_out  out  NumLanes*OutBits  registered lane outputs
data_valid  out  1  1 while state=RUN
seed_good  out  NumLanes  per-lane prbs_seed_good
state_out  out  3  FSM state encoding
timeout_err  out  1  1 while state=FAIL

Behaviour:
- Reset clears all sequencer/config flops. Reset values: data_out=0, data_valid=0, state=IDLE (3'd0), timeout_err=0. pattern_generator cores are tied reset=0; their internal state is not reset.
- cfg_start passes through a 2-flop synchronizer. cfg_pattern, cfg_self_seed, cfg_inv, cfg_seed are quasi-static.
  - cfg_pattern and cfg_self_seed are captured on the IDLE->LOAD transition and held until the next IDLE.
  - cfg_inv passes through a 1-flop register and is applied live.
- Core controls per state:
  - IDLE(0): load=1, run=0, seed=0.
  - LOAD(1): load=1, run=0, seed=0.
  - SEED(2): load=0, run=1, seed=1.
  - RUN(3): load=0, run=1, seed=0.
  - FAIL(4): load=1, run=0, seed=0.
  - load_in=cfg_seed in all states.
- Transitions:
  - IDLE: synced start=1 -> LOAD.
  - LOAD: held exactly 2 cycles. Then -> SEED if captured self_seed=1 and pattern=0, else -> RUN.
  - SEED: a 16-bit counter clears on entry and increments each cycle. Go to RUN when counter>=SeedCycles-1 and &seed_good. Otherwise go to FAIL when counter==SeedTimeout-1. If both hold in the same cycle, RUN wins.
  - RUN: synced start=0 -> IDLE.
  - FAIL: synced start=0 -> IDLE. Restart requires start low for at least 1 synced cycle.
  - Any state except IDLE: synced start=0 -> IDLE next cycle. This overrides every other transition.
- data_out register: lane i = core_out_i when next state is RUN, else 0. Core out_inv = cfg_inv registered. data_valid has identical timing, so data_valid and nonzero data appear on the same edge.
- Start-to-valid latency, measured from the cfg_start edge:
  - No self-seed: 2 sync + 1 (IDLE->LOAD) + 2 (LOAD) = 5 cycles to first data_valid.
  - Self-seed: 5 + seed-phase duration.
- Reset asserted mid-RUN: outputs are 0 asynchronously. After reset release the block restarts from IDLE and needs start resynchronised.

Optional Feature:
PGEN_ERR_INJECT_EN.
- Present: adds inputs err_inj (1, pulse) and err_inj_lane ($clog2(NumLanes)), and output err_inj_count (16, saturating at 16'hFFFF, reset 0).
  - err_inj is rising-edge detected after the 2-flop synchronizer.
  - While in RUN, each detected edge XORs bit 0 of the selected lane in the data_out register for exactly one cycle and increments err_inj_count.
  - Edges outside RUN are ignored and not counted.
- Absent: none of these ports exist; data_out is never corrupted.

Test Plan:
- PRBS load/run: cfg_pattern=0, cfg_self_seed=0, cfg_seed=31'h1, start=1 -> data_valid rises 5 cycles after start. Each lane's data_out matches the PRBS31 reference from seed 1, and all lanes are identical.
- Pattern + invert: cfg_pattern=1, cfg_seed=32'hF0F0_F0F0, cfg_inv=4'b0010 -> lanes 0/2/3 output 16'hF0F0 every cycle, lane 1 outputs 16'h0F0F.
- Self-seed lock: cfg_self_seed=1, pgen_seed_in driven with a valid PRBS31 stream -> SEED lasts ≥64 cycles, then RUN. seed_good=4'hF, and lanes track their inputs' PRBS.
- Seed timeout: cfg_self_seed=1, pgen_seed_in=0 -> FAIL after exactly 1024 SEED cycles, timeout_err=1, data_out=0. Dropping start -> IDLE and timeout_err=0.
- Stop/reset mid-run: start=0 in RUN -> data_valid=0 and data_out=0 within 3 cycles. Async reset pulse in RUN -> outputs 0 immediately, state 0.
- (PGEN_ERR_INJECT_EN) err_inj pulse with lane=2 in RUN -> lane 2 bit 0 flips for one cycle and err_inj_count=1. The same pulse in IDLE -> count unchanged.
